irq_capture4: RTL

Four-line request capture and one-hot presenter placed directly upstream of the 4-to-2 priority encoder. It latches request events into a pending register and selects one enabled pending line. It drives that line to the encoder as a strictly one-hot vector and takes the encoded 2-bit index back from the encoder. It then offers the index to a consumer over a valid/ready handshake and clears the serviced line on acceptance.

---
 rtl/irq_capture4.sv | 109 ++++++++++
 1 files changed

// File: rtl/irq_capture4.sv
// Four-line request capture feeding a one-hot vector to an external encoder
// and offering the returned index to a consumer over valid/ready.
module irq_capture4 #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  output logic [3:0] onehot,
  input  logic [1:0] idx,
  output logic       valid,
  input  logic       ready,
  output logic [1:0] id,
  output logic [3:0] pending,
  output logic [3:0] ovf,
  input  logic       ovf_clr
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    OFFER
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [3:0] req_q;
  logic [3:0] evt;
  logic [3:0] clr;
  logic [3:0] elig;
  logic [3:0] pick;
  logic [3:0] ovf_set;
  logic [3:0] onehot_n;
  logic [1:0] id_n;
  logic       valid_n;
  logic       accept;

  assign evt     = EDGE ? (req & ~req_q) : req;
  assign accept  = (state == OFFER) & ready;
  assign clr     = accept ? onehot : 4'b0000;
  assign elig    = pending & mask;
  // Only a fresh event on a still-pending, not-now-cleared line is lost.
  assign ovf_set = EDGE ? (evt & pending & ~clr) : 4'b0000;

  always_comb begin
    pick = 4'b0000;
    if (elig[3])      pick = 4'b1000;
    else if (elig[2]) pick = 4'b0100;
    else if (elig[1]) pick = 4'b0010;
    else if (elig[0]) pick = 4'b0001;
  end

  always_comb begin
    state_n  = state;
    onehot_n = onehot;
    valid_n  = valid;
    id_n     = id;
    unique case (state)
      IDLE: begin
        if (|elig) begin
          onehot_n = pick;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        id_n    = idx;
        valid_n = 1'b1;
        state_n = OFFER;
      end
      OFFER: begin
        if (ready) begin
          valid_n  = 1'b0;
          onehot_n = 4'b0000;
          state_n  = IDLE;
        end
      end
      default: begin
        valid_n  = 1'b0;
        onehot_n = 4'b0000;
        state_n  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // req_q tracks req even in reset so a held line gives no event.
    req_q <= req;
    if (rst) begin
      pending <= 4'b0000;
      ovf     <= 4'b0000;
      state   <= IDLE;
      onehot  <= 4'b0000;
      valid   <= 1'b0;
      id      <= 2'd0;
    end else begin
      pending <= (pending & ~clr) | evt;
      if (EDGE)
        ovf <= (ovf & ~{4{ovf_clr}}) | ovf_set;
      else
        ovf <= 4'b0000;
      state   <= state_n;
      onehot  <= onehot_n;
      valid   <= valid_n;
      id      <= id_n;
    end
  end

endmodule
